// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns a 256x8 program memory and the PC, issues one
// instruction at a time to the control unit and waits out BNZ resolution.
module instr_fetch #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       load_en_i,
   input  logic [7:0] load_addr_i,
   input  logic [7:0] load_data_i,
   output logic [7:0] instr_o,
   output logic       instr_valid_o,
   input  logic       instr_ready_i,
   output logic [7:0] pc_o,
   input  logic       br_resolve_i,
   input  logic       br_taken_i,
   input  logic [7:0] br_target_i,
   output logic       busy_o,
   output logic       halted_o
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StIssue,
      StBrWait,
      StHalt
   } state_e;

   localparam logic [2:0] OpBnz = 3'b100;

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] instr_q, instr_d;
   logic       valid_q, valid_d;
   logic       mem_we;
   logic [7:0] mem_q [256];

   // Contents are deliberately not reset so a loaded program survives rst.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[load_addr_i] <= load_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         instr_q <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle, StHalt: begin
            valid_d = 1'b0;
            // Loads are gated by rst too, so a reset cycle never writes memory.
            mem_we  = load_en_i && !rst_i;
            if (start_i) begin
               pc_d    = RESET_PC;
               state_d = StFetch;
            end
         end
         StFetch: begin
            instr_d = mem_q[pc_q];
            valid_d = 1'b1;
            state_d = StIssue;
         end
         StIssue: begin
            if (valid_q && instr_ready_i) begin
               valid_d = 1'b0;
               if (instr_q[7:5] == OpBnz) begin
                  state_d = StBrWait;
               end else if (pc_q == 8'hFF) begin
                  state_d = StHalt;
               end else begin
                  pc_d    = pc_q + 8'd1;
                  state_d = StFetch;
               end
            end
         end
         StBrWait: begin
            valid_d = 1'b0;
            if (br_resolve_i) begin
               if (br_taken_i) begin
                  pc_d    = br_target_i;
                  state_d = StFetch;
               end else if (pc_q == 8'hFF) begin
                  state_d = StHalt;
               end else begin
                  pc_d    = pc_q + 8'd1;
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;
   assign busy_o        = (state_q == StFetch) || (state_q == StIssue) || (state_q == StBrWait);
   assign halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hand-computed instruction stream, stalls,
// branches, halt at 8'hFF, reset in BRWAIT and blocked loads.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst, start, load_en, instr_ready;
   logic [7:0] load_addr, load_data, br_target;
   logic       br_resolve, br_taken;
   logic [7:0] instr, pc;
   logic       instr_valid, busy, halted;

   int n_total = 0;
   int n_bad   = 0;

   instr_fetch #(.RESET_PC(8'h00)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .load_en_i    (load_en),
      .load_addr_i  (load_addr),
      .load_data_i  (load_data),
      .instr_o      (instr),
      .instr_valid_o(instr_valid),
      .instr_ready_i(instr_ready),
      .pc_o         (pc),
      .br_resolve_i (br_resolve),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .busy_o       (busy),
      .halted_o     (halted)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic expect_instr(input string tag, input logic [7:0] i, input logic [7:0] p);
      check_eq({tag, ".valid"}, {7'b0, instr_valid}, 8'h01);
      check_eq({tag, ".instr"}, instr, i);
      check_eq({tag, ".pc"}, pc, p);
   endtask

   task automatic expect_gap(input string tag, input logic [7:0] p);
      check_eq({tag, ".valid"}, {7'b0, instr_valid}, 8'h00);
      check_eq({tag, ".pc"}, pc, p);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; load_en = 1'b0; instr_ready = 1'b0;
      load_addr = 8'h00; load_data = 8'h00;
      br_resolve = 1'b0; br_taken = 1'b0; br_target = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst.pc", pc, 8'h00);
      check_eq("rst.instr", instr, 8'h00);
      check_eq("rst.valid", {7'b0, instr_valid}, 8'h00);
      check_eq("rst.busy", {7'b0, busy}, 8'h00);
      check_eq("rst.halted", {7'b0, halted}, 8'h00);

      load(8'h00, 8'h21);
      load(8'h01, 8'h45);
      load(8'h02, 8'hA3);
      load(8'h03, 8'h80);
      load(8'h10, 8'h3C);
      load(8'h11, 8'h9F);
      load(8'h12, 8'h66);
      load(8'h13, 8'h80);
      load(8'hFF, 8'h5A);

      // Start: FETCH after the sampling edge, instr_valid one edge later.
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("fetch.busy", {7'b0, busy}, 8'h01);
      check_eq("fetch.valid", {7'b0, instr_valid}, 8'h00);
      instr_ready = 1'b1;
      tick();
      expect_instr("i0", 8'h21, 8'h00);
      tick();
      expect_gap("hs0", 8'h01);
      instr_ready = 1'b0;
      tick();
      expect_instr("i1", 8'h45, 8'h01);

      // Stall in ISSUE; start and a load to address 0 must both be ignored.
      start     = 1'b1;
      load_en   = 1'b1;
      load_addr = 8'h00;
      load_data = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_instr("stall", 8'h45, 8'h01);
      end
      start   = 1'b0;
      load_en = 1'b0;
      instr_ready = 1'b1;
      tick();
      expect_gap("hs1", 8'h02);
      instr_ready = 1'b0;
      tick();
      expect_instr("i2", 8'hA3, 8'h02);
      instr_ready = 1'b1;
      tick();
      expect_gap("hs2", 8'h02 + 8'h01);
      tick();
      expect_instr("bnz3", 8'h80, 8'h03);

      // Resolve during the BNZ handshake itself must be ignored.
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h20;
      tick();
      br_resolve = 1'b0;
      expect_gap("brw.enter", 8'h03);
      check_eq("brw.busy", {7'b0, busy}, 8'h01);
      tick();
      tick();
      expect_gap("brw.hold", 8'h03);
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h10;
      tick();
      br_resolve = 1'b0;
      expect_gap("taken", 8'h10);
      tick();
      expect_instr("i10", 8'h3C, 8'h10);
      tick();
      tick();
      expect_instr("bnz11", 8'h9F, 8'h11);
      tick();
      br_resolve = 1'b1; br_taken = 1'b0; br_target = 8'h40;
      tick();
      br_resolve = 1'b0;
      expect_gap("nottaken", 8'h12);
      tick();
      expect_instr("i12", 8'h66, 8'h12);
      tick();
      tick();
      expect_instr("bnz13", 8'h80, 8'h13);
      tick();

      // Reset in BRWAIT with resolve and start high.
      rst = 1'b1; start = 1'b1;
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h40;
      tick();
      rst = 1'b0; start = 1'b0; br_resolve = 1'b0;
      check_eq("rst2.pc", pc, 8'h00);
      check_eq("rst2.valid", {7'b0, instr_valid}, 8'h00);
      check_eq("rst2.busy", {7'b0, busy}, 8'h00);
      check_eq("rst2.halted", {7'b0, halted}, 8'h00);
      tick();
      check_eq("rst2.idle", {7'b0, busy}, 8'h00);

      // Restart: memory survived reset and the blocked load.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      expect_instr("re0", 8'h21, 8'h00);
      tick(); tick();
      expect_instr("re1", 8'h45, 8'h01);
      tick(); tick();
      tick(); tick();
      expect_instr("re3", 8'h80, 8'h03);
      tick();
      br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
      tick();
      br_resolve = 1'b0;
      expect_gap("toFF", 8'hFF);
      tick();
      expect_instr("iFF", 8'h5A, 8'hFF);
      tick();
      check_eq("halt.halted", {7'b0, halted}, 8'h01);
      check_eq("halt.busy", {7'b0, busy}, 8'h00);
      expect_gap("halt", 8'hFF);
      tick();
      check_eq("halt.stay", {7'b0, halted}, 8'h01);
      expect_gap("halt.stay", 8'hFF);

      // Load and start together in HALT: write lands, then fetch sees it.
      load_en = 1'b1; load_addr = 8'h00; load_data = 8'h33; start = 1'b1;
      tick();
      load_en = 1'b0; start = 1'b0;
      check_eq("hstart.busy", {7'b0, busy}, 8'h01);
      check_eq("hstart.halted", {7'b0, halted}, 8'h00);
      check_eq("hstart.pc", pc, 8'h00);
      tick();
      expect_instr("h0", 8'h33, 8'h00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
